// File: rtl/demux_router_buffered.sv
// demux_router_buffered: routes one val/rdy message stream to one of
// p_noutputs val/rdy outputs, each backed by its own p_depth-entry FIFO so a
// stalled consumer only blocks traffic bound for its own output.
module demux_router_buffered #(
  parameter int p_nbits    = 8,
  parameter int p_noutputs = 4,
  parameter int p_depth    = 2
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [p_nbits-1:0]                          recv_msg,
  input  logic [$clog2(p_noutputs)-1:0]               recv_sel,
  input  logic                                        recv_val,
  output logic                                        recv_rdy,
  output logic [p_noutputs*p_nbits-1:0]               send_msg,
  output logic [p_noutputs-1:0]                       send_val,
  input  logic [p_noutputs-1:0]                       send_rdy,
  output logic [p_noutputs*$clog2(p_depth+1)-1:0]     occupancy,
  output logic                                        sel_err
);

  localparam int sw = $clog2(p_noutputs);
  localparam int cw = $clog2(p_depth + 1);
  localparam int pw = (p_depth > 1) ? $clog2(p_depth) : 1;

  logic [p_noutputs-1:0] full;
  logic                  sel_ok;
  logic                  sel_free;
  logic                  accept;

  // Decode the select against registered fullness only; an out-of-range
  // select is always accepted so the offending message can be dropped.
  always_comb begin
    sel_ok   = 1'b0;
    sel_free = 1'b1;
    for (int i = 0; i < p_noutputs; i++) begin
      if (recv_sel == sw'(i)) begin
        sel_ok   = 1'b1;
        sel_free = !full[i];
      end
    end
  end

  assign recv_rdy = !reset && sel_free;
  assign accept   = recv_val && recv_rdy;

  // Sticky flag for messages addressed to a non-existent output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sel_err <= 1'b0;
    else if (accept && !sel_ok) sel_err <= 1'b1;
  end

  for (genvar g = 0; g < p_noutputs; g++) begin : g_out
    logic [pw-1:0]      head;
    logic [pw-1:0]      tail;
    logic [cw-1:0]      cnt;
    logic [p_nbits-1:0] mem [p_depth];
    logic               enq;
    logic               deq;

    assign enq       = accept && (recv_sel == sw'(g));
    assign deq       = send_val[g] && send_rdy[g];
    assign full[g]   = (cnt == cw'(p_depth));
    assign send_val[g] = (cnt != '0);
    assign send_msg[(p_noutputs-g)*p_nbits-1 -: p_nbits] = send_val[g] ? mem[head] : '0;
    assign occupancy[(p_noutputs-g)*cw-1 -: cw]          = cnt;

    // Pointer and count update; wrap by explicit compare so any depth works.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        head <= '0;
        tail <= '0;
        cnt  <= '0;
      end else begin
        if (enq) tail <= (tail == pw'(p_depth - 1)) ? '0 : tail + pw'(1);
        if (deq) head <= (head == pw'(p_depth - 1)) ? '0 : head + pw'(1);
        if (enq && !deq)      cnt <= cnt + cw'(1);
        else if (!enq && deq) cnt <= cnt - cw'(1);
      end
    end

    // Storage needs no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge clk) begin
      if (enq) mem[tail] <= recv_msg;
    end
  end

endmodule

// File: tb/tb_demux_router_buffered.sv
// Directed bench for demux_router_buffered with a per-output scoreboard.
module tb_demux_router_buffered;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  // dut_a: defaults (8 bits, 4 outputs, depth 2)
  logic [7:0]  a_msg;
  logic [1:0]  a_sel;
  logic        a_val, a_rdy, a_err;
  logic [31:0] a_smsg;
  logic [3:0]  a_sval, a_srdy;
  logic [7:0]  a_occ;

  // dut_b: 3 outputs, depth 2 (invalid select)
  logic [7:0]  b_msg;
  logic [1:0]  b_sel;
  logic        b_val, b_rdy, b_err;
  logic [23:0] b_smsg;
  logic [2:0]  b_sval, b_srdy;
  logic [5:0]  b_occ;

  // dut_c: 4 outputs, depth 3 (non-power-of-two wrap)
  logic [7:0]  c_msg;
  logic [1:0]  c_sel;
  logic        c_val, c_rdy, c_err;
  logic [31:0] c_smsg;
  logic [3:0]  c_sval, c_srdy;
  logic [7:0]  c_occ;

  demux_router_buffered #(.p_nbits(8), .p_noutputs(4), .p_depth(2)) dut_a (
    .clk(clk), .reset(reset), .recv_msg(a_msg), .recv_sel(a_sel), .recv_val(a_val),
    .recv_rdy(a_rdy), .send_msg(a_smsg), .send_val(a_sval), .send_rdy(a_srdy),
    .occupancy(a_occ), .sel_err(a_err));

  demux_router_buffered #(.p_nbits(8), .p_noutputs(3), .p_depth(2)) dut_b (
    .clk(clk), .reset(reset), .recv_msg(b_msg), .recv_sel(b_sel), .recv_val(b_val),
    .recv_rdy(b_rdy), .send_msg(b_smsg), .send_val(b_sval), .send_rdy(b_srdy),
    .occupancy(b_occ), .sel_err(b_err));

  demux_router_buffered #(.p_nbits(8), .p_noutputs(4), .p_depth(3)) dut_c (
    .clk(clk), .reset(reset), .recv_msg(c_msg), .recv_sel(c_sel), .recv_val(c_val),
    .recv_rdy(c_rdy), .send_msg(c_smsg), .send_val(c_sval), .send_rdy(c_srdy),
    .occupancy(c_occ), .sel_err(c_err));

  logic [7:0] qa [4][$];
  logic [7:0] qc [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One dut_a cycle: inputs already driven just after an edge; check the
  // outputs mid-cycle against the model, then advance the model and clock.
  task automatic cyc_a();
    logic exp_rdy;
    #3;
    exp_rdy = (qa[a_sel].size() < 2);
    chk("a_recv_rdy", {31'd0, a_rdy}, {31'd0, exp_rdy});
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("a_occ%0d", i), {30'd0, a_occ[(4-i)*2-1 -: 2]}, qa[i].size());
      chk($sformatf("a_val%0d", i), {31'd0, a_sval[i]}, {31'd0, qa[i].size() != 0});
      chk($sformatf("a_msg%0d", i), {24'd0, a_smsg[(4-i)*8-1 -: 8]},
          {24'd0, (qa[i].size() != 0) ? qa[i][0] : 8'h00});
    end
    for (int i = 0; i < 4; i++)
      if (qa[i].size() != 0 && a_srdy[i]) void'(qa[i].pop_front());
    if (a_val && exp_rdy) qa[a_sel].push_back(a_msg);
    @(posedge clk); #1;
  endtask

  task automatic send_a(input logic [1:0] sel, input logic [7:0] msg);
    a_sel = sel; a_msg = msg; a_val = 1'b1;
    cyc_a();
    a_val = 1'b0;
  endtask

  int next_v;
  logic exp_c;

  initial begin
    a_msg = '0; a_sel = '0; a_val = 1'b0; a_srdy = '0;
    b_msg = '0; b_sel = '0; b_val = 1'b0; b_srdy = '1;
    c_msg = '0; c_sel = '0; c_val = 1'b0; c_srdy = '0;

    // Reset state
    #2;
    chk("rst_sval", {28'd0, a_sval}, 32'd0);
    chk("rst_occ", {24'd0, a_occ}, 32'd0);
    chk("rst_err", {31'd0, a_err}, 32'd0);
    chk("rst_rdy", {31'd0, a_rdy}, 32'd0);
    chk("rst_b_err", {31'd0, b_err}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Scenario 1: one message per output, all consumers ready
    a_srdy = 4'hF;
    for (int i = 0; i < 4; i++) send_a(i[1:0], 8'hA0 + i[7:0]);
    repeat (3) cyc_a();

    // Scenario 2: backpressure on output 2, output 1 still accepts
    a_srdy = 4'h0;
    send_a(2'd2, 8'h11);
    send_a(2'd2, 8'h22);
    send_a(2'd2, 8'h33);          // refused: FIFO 2 full
    send_a(2'd1, 8'h44);
    a_srdy = 4'b0100;
    a_sel = 2'd2; a_msg = 8'h33; a_val = 1'b1;
    cyc_a();                      // pop 0x11, rdy still 0
    cyc_a();                      // rdy 1, 0x33 accepted
    a_val = 1'b0;
    cyc_a();
    a_srdy = 4'hF;
    repeat (4) cyc_a();

    // Scenario 3: full FIFO 0 with simultaneous pop
    a_srdy = 4'h0;
    send_a(2'd0, 8'hB0);
    send_a(2'd0, 8'hB1);
    a_srdy = 4'b0001;
    a_sel = 2'd0; a_msg = 8'hB2; a_val = 1'b1;
    cyc_a();
    cyc_a();
    a_val = 1'b0;
    a_srdy = 4'hF;
    repeat (4) cyc_a();

    // Scenario 4: invalid select on the 3-output instance
    b_sel = 2'd3; b_msg = 8'h5A; b_val = 1'b1;
    #3;
    chk("b_inv_rdy", {31'd0, b_rdy}, 32'd1);
    @(posedge clk); #1;
    b_val = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #3;
      chk("b_err_sticky", {31'd0, b_err}, 32'd1);
      chk("b_no_sval", {29'd0, b_sval}, 32'd0);
      chk("b_no_occ", {26'd0, b_occ}, 32'd0);
      @(posedge clk); #1;
    end
    b_srdy = 3'b000;
    b_sel = 2'd2; b_msg = 8'h77; b_val = 1'b1;
    @(posedge clk); #1;
    b_val = 1'b0;
    #3;
    chk("b_sval2", {29'd0, b_sval}, 32'd4);
    chk("b_msg2", {24'd0, b_smsg[7:0]}, 32'h77);
    chk("b_err_hold", {31'd0, b_err}, 32'd1);
    @(posedge clk); #1;

    // Scenario 5: reset mid-operation with occupancy {2,1,0,2}
    a_srdy = 4'h0;
    send_a(2'd0, 8'hC0);
    send_a(2'd0, 8'hC1);
    send_a(2'd1, 8'hC2);
    send_a(2'd3, 8'hC3);
    send_a(2'd3, 8'hC4);
    #3;
    chk("pre_rst_occ", {24'd0, a_occ}, 32'b10_01_00_10);
    reset = 1'b1;
    #1;
    chk("mid_rst_sval", {28'd0, a_sval}, 32'd0);
    chk("mid_rst_occ", {24'd0, a_occ}, 32'd0);
    chk("mid_rst_err", {31'd0, a_err}, 32'd0);
    chk("mid_rst_rdy", {31'd0, a_rdy}, 32'd0);
    chk("mid_rst_b_err", {31'd0, b_err}, 32'd0);
    for (int i = 0; i < 4; i++) qa[i].delete();
    @(posedge clk); #1;
    reset = 1'b0;
    a_srdy = 4'hF;
    for (int i = 0; i < 4; i++) send_a(i[1:0], 8'hA0 + i[7:0]);
    repeat (3) cyc_a();
    chk("post_rst_b_err", {31'd0, b_err}, 32'd0);

    // Scenario 6: depth-3 FIFO, 10 values through output 3, random send_rdy
    next_v = 0;
    c_sel = 2'd3;
    for (int k = 0; k < 300; k++) begin
      c_val = (next_v < 10);
      c_msg = next_v[7:0];
      c_srdy = {$urandom_range(0, 1) == 1, 3'b000};
      #3;
      exp_c = (qc.size() < 3);
      chk("c_recv_rdy", {31'd0, c_rdy}, {31'd0, exp_c});
      chk("c_occ3", {30'd0, c_occ[1:0]}, qc.size());
      chk("c_occ_max", {31'd0, c_occ[1:0] <= 2'd3}, 32'd1);
      chk("c_val3", {31'd0, c_sval[3]}, {31'd0, qc.size() != 0});
      chk("c_msg3", {24'd0, c_smsg[7:0]}, {24'd0, (qc.size() != 0) ? qc[0] : 8'h00});
      if (qc.size() != 0 && c_srdy[3]) void'(qc.pop_front());
      if (c_val && exp_c) begin
        qc.push_back(c_msg);
        next_v++;
      end
      @(posedge clk); #1;
      if (next_v == 10 && qc.size() == 0) break;
    end
    c_val = 1'b0;
    c_srdy = 4'h0;
    chk("c_all_sent", next_v, 32'd10);
    chk("c_all_drained", qc.size(), 32'd0);
    #3;
    chk("c_final_occ", {24'd0, c_occ}, 32'd0);
    chk("c_final_sval", {28'd0, c_sval}, 32'd0);
    chk("c_no_err", {31'd0, c_err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/demux_router_buffered.md
Name: demux_router_buffered

Overview:
- Parametrised, registered successor to the combinational demux.
- Routes one input message stream to one of p_noutputs output ports, chosen by a per-message select.
- Uses val/rdy handshakes on both sides and a private FIFO per output, so one stalled output does not block traffic bound for the others once the message is queued.
- Sits between a packet source and the per-destination links of the routing interconnect.

Parameters:
- p_nbits, 8, message width in bits (>=1).
- p_noutputs, 4, number of output ports (>=2; need not be a power of two).
- p_depth, 2, entries per output FIFO (>=1; need not be a power of two).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- recv_msg  input  p_nbits  incoming message.
- recv_sel  input  $clog2(p_noutputs)  destination output index for recv_msg.
- recv_val  input  1  recv_msg/recv_sel valid.
- recv_rdy  output  1  block can accept this cycle.
- send_msg  output  p_noutputs*p_nbits  flattened output messages.
  - Output i occupies bits [(p_noutputs-i)*p_nbits-1 -: p_nbits], so output 0 is the most-significant slice.
- send_val  output  p_noutputs  bit i: output i holds a valid message.
- send_rdy  input  p_noutputs  bit i: consumer of output i accepts.
- occupancy  output  p_noutputs*$clog2(p_depth+1)  per-output entry counts, same slice ordering as send_msg.
- sel_err  output  1  sticky: a message with recv_sel >= p_noutputs was received.

Behaviour:
- Reset, asynchronous and taking effect immediately:
  - all FIFOs empty, pointers 0, occupancy 0;
  - send_val all 0, sel_err 0.
  - recv_rdy=1 while reset is low after reset; it is 0 while reset is high.
- Reset mid-operation flushes all queued messages; no partial state survives.
- recv_rdy:
  - 1 when recv_sel < p_noutputs and FIFO[recv_sel] is not full.
  - 1 when recv_sel >= p_noutputs (the message is dropped).
  - Depends only on recv_sel and registered state, never on send_rdy. No combinational rdy path through the block.
- Enqueue (recv_val & recv_rdy, valid sel): recv_msg is written at FIFO[recv_sel] tail; that tail pointer and count advance.
- Invalid sel with recv_val & recv_rdy: message discarded, sel_err set to 1 on that edge. sel_err stays 1 until reset.
- Latency:
  - A message accepted on edge t appears on send_msg slice sel with send_val=1 from cycle t+1.
  - There is no same-cycle bypass.
- Dequeue per output i (send_val[i] & send_rdy[i]): the head pops and the next entry, if any, is presented the next cycle.
- Outputs dequeue independently and concurrently.
- send_val[i] = (count_i != 0). send_msg slice i = FIFO i head while send_val[i]=1; when empty the slice is all zeros.
- send_val must not depend combinationally on send_rdy.
- Full FIFO, simultaneous dequeue:
  - recv_rdy for that sel is 0 even if send_rdy[i]=1 the same cycle (no pipe-through).
  - Space frees on the following cycle.
- Simultaneous enqueue and dequeue on a non-full, non-empty FIFO: count unchanged; both pointers advance.
- Empty FIFO, simultaneous enqueue: the entry is not visible that cycle; send_val rises next cycle.
- Pointers wrap from p_depth-1 to 0 by explicit compare, valid for non-power-of-two depth.
- Message ordering: FIFO order preserved per output. No ordering guarantee across outputs.
- recv_msg and recv_sel are sampled only on the accepting edge. Values while recv_val=0 are ignored.

Test Plan:
- Reset, defaults (p_nbits=8, p_noutputs=4, p_depth=2):
  - send msgs 0xA0,0xA1,0xA2,0xA3 to sel 0,1,2,3 on consecutive cycles with all send_rdy=1;
  - each send_val[i] pulses one cycle after acceptance with the matching value in slice i; occupancy returns to 0.
- Backpressure and isolation:
  - send_rdy=4'b0000; send 0x11,0x22,0x33 to sel 2;
  - recv_rdy goes 0 after the 2nd is accepted, occupancy[2]=2;
  - a message 0x44 to sel 1 is still accepted;
  - then raising send_rdy[2] drains 0x11 then 0x22 in order, and 0x33 is accepted one cycle after the first pop.
- Full plus simultaneous pop:
  - FIFO 0 full with send_rdy[0]=1 and recv_val to sel 0: recv_rdy=0 that cycle and 1 the next.
- Invalid select, p_noutputs=3:
  - recv_sel=3, msg 0x5A, recv_val=1;
  - recv_rdy=1, no send_val asserted, sel_err=1 and stays 1 for the remaining cycles until reset.
- Reset mid-operation:
  - with occupancy {2,1,0,2}, assert reset asynchronously between edges;
  - send_val=0 and occupancy=0 immediately, sel_err=0; the post-reset stream behaves as in the first scenario.
- Non-power-of-two depth, p_depth=3:
  - push and pop 10 sequential values 0x00..0x09 through output 3 with random send_rdy;
  - output order is exact, pointers wrap correctly, occupancy never exceeds 3.
